data_cache_controller: RTL and testbench
========================================

Name: data_cache_controller

Overview:
Direct-mapped, write-through, no-write-allocate L1 data cache for the data-memory stage. It is the responder to the pipeline's hazard control. It answers load/store requests and drives DATA_CACHE_READY, which the hazard control unit consumes. It also obeys STALL_DATA_CACHE from that unit. Misses refill a whole line from main memory over a burst-read handshake; stores go straight through to memory over a write handshake.

Parameters:
ADDRESS_WIDTH, 32, byte-address width
LINES, 64, number of cache lines (power of 2, ≥2)
LINE_WORDS, 4, 32-bit words per line (power of 2, ≥2)

Ports:
CLK  in  1  system clock
RST  in  1  reset
STALL_DATA_CACHE  in  1  freeze request acceptance and DATA_OUT
ADDRESS  in  ADDRESS_WIDTH  byte address of current request
DATA_CACHE_LOAD  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 111 no load; other codes = no load
DATA_CACHE_STORE  in  2  00 none, 01 SB, 10 SH, 11 SW
WRITE_DATA  in  32  store data, right-aligned
DATA_OUT  out  32  registered, extended load result
DATA_CACHE_READY  out  1  high = request completes this cycle / no request
MEM_ADDRESS  out  ADDRESS_WIDTH  memory request address
MEM_READ_REQ  out  1  burst refill request
MEM_READ_VALID  in  1  one refill word valid
MEM_READ_DATA  in  32  refill word
MEM_WRITE_REQ  out  1  single-word write request
MEM_WRITE_DATA  out  32  byte-lane-aligned store data
MEM_WRITE_STRB  out  4  byte enables
MEM_WRITE_ACK  in  1  write accepted

Behaviour:
- One clock, CLK. Reset RST is synchronous and active-high.
- While RST is high, at the clock edge:
  - state ← IDLE; all valid bits ← 0; refill counter ← 0
  - DATA_OUT ← 0; MEM_READ_REQ, MEM_WRITE_REQ ← 0; MEM_ADDRESS, MEM_WRITE_DATA, MEM_WRITE_STRB ← 0
  - DATA_CACHE_READY is forced to 1 while RST is high.
- Address split: offset = low 2+log2(LINE_WORDS) bits; index = next log2(LINES) bits; tag = remainder. Misaligned low bits are ignored: LW ignores [1:0], LH/LHU ignore [0].
- A request is active when the state is IDLE, STALL_DATA_CACHE = 0, and the load or store field is non-null. If both are non-null, the store wins and the load is ignored.
- States: IDLE, REFILL, WRITE.
- IDLE, load hit: READY = 1 combinationally. DATA_OUT is updated at the edge (1-cycle latency) with the selected byte/half/word, sign- or zero-extended per code.
- IDLE, load miss: READY = 0 combinationally. Next state REFILL. MEM_ADDRESS ← line base (offset zeroed). MEM_READ_REQ ← 1.
- REFILL:
  - READY = 0. MEM_READ_REQ is held high until the last beat.
  - Each MEM_READ_VALID writes word[counter] and increments the counter.
  - On the beat with counter = LINE_WORDS-1: set the tag and valid bit, counter wraps to 0, MEM_READ_REQ ← 0, go to IDLE.
  - The still-present load then hits in IDLE and completes normally, so total miss latency = LINE_WORDS beats + 2 cycles.
- IDLE, store: READY = 0. Go to WRITE with:
  - MEM_ADDRESS ← word-aligned address; MEM_WRITE_REQ ← 1
  - MEM_WRITE_DATA = data replicated to lanes (SB ×4, SH ×2)
  - MEM_WRITE_STRB: SB 0001<<addr[1:0]; SH 0011 or 1100 by addr[1]; SW 1111
  - On a hit, merge the byte-enabled bytes into the cached word in the same edge. On a miss, no allocate.
- WRITE: READY = MEM_WRITE_ACK combinationally. On ACK: MEM_WRITE_REQ ← 0, go to IDLE. The pipeline advances on that same cycle, so the store is not reissued.
- STALL_DATA_CACHE = 1 in IDLE: request ignored, DATA_OUT holds, READY = 1, no memory request launched. In REFILL/WRITE, stall has no effect; an in-flight transaction completes.
- MEM_READ_VALID outside REFILL and MEM_WRITE_ACK outside WRITE are ignored.
- Reset mid-REFILL or mid-WRITE: abort, requests drop next edge, the partially filled line stays invalid.

Test Plan:
- Reset, then LW 0x100 → READY low, MEM_READ_REQ=1, MEM_ADDRESS=0x100. Feed 4 beats 0xA0..0xA3 → IDLE. Next cycle READY=1; edge after, DATA_OUT=0xA0.
- After that fill, LB 0x107 (word 0xA1, byte3=0x00) and LB 0x104 with word set to 0x000000F0 → DATA_OUT=0xFFFFFFF0. LBU same address → 0x000000F0. LH 0x106 on 0x8001xxxx → 0xFFFF8001.
- SH 0x102 data 0x1234 on cached line → MEM_WRITE_STRB=1100, MEM_WRITE_DATA=0x12341234. READY low until ACK after 3 cycles, READY=1 on ACK cycle. Subsequent LW 0x100 hits → 0x123400A0.
- SW to an uncached address 0x800 → memory write issued; following LW 0x800 misses (no allocate).
- Alias: LW 0x100 filled, then LW 0x100+LINES*LINE_WORDS*4 → miss and refill replace the line. LW 0x100 then misses again.
- RST asserted after 2 refill beats → MEM_READ_REQ=0 next edge, READY=1. Later LW 0x100 misses and refills from beat 0. STALL_DATA_CACHE=1 with LW miss in IDLE → no MEM_READ_REQ, DATA_OUT unchanged.

Source files
------------

// File: rtl/data_cache_controller.sv
// data_cache_controller
//   Direct-mapped, write-through, no-write-allocate L1 data cache for the
//   data-memory stage. Load misses refill a whole line over a burst-read
//   handshake; stores are written through over a single-word write handshake
//   and merged into the cached line on a hit.
//
// Ports
//   CLK, RST              clock, synchronous active-high reset
//   STALL_DATA_CACHE      freezes request acceptance and DATA_OUT while idle
//   ADDRESS               byte address of the current request
//   DATA_CACHE_LOAD       load code (LB/LH/LW/LBU/LHU, others = no load)
//   DATA_CACHE_STORE      store code (none/SB/SH/SW)
//   WRITE_DATA            right-aligned store data
//   DATA_OUT              registered, extended load result
//   DATA_CACHE_READY      request completes this cycle / no request
//   MEM_ADDRESS           memory request address (line base or word address)
//   MEM_READ_REQ          burst refill request
//   MEM_READ_VALID/DATA   refill beat handshake
//   MEM_WRITE_REQ/DATA/STRB  write-through request, lane-aligned data, byte enables
//   MEM_WRITE_ACK         write accepted
module data_cache_controller #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned LINES         = 64,
    parameter int unsigned LINE_WORDS    = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     STALL_DATA_CACHE,
    input  logic [ADDRESS_WIDTH-1:0] ADDRESS,
    input  logic [2:0]               DATA_CACHE_LOAD,
    input  logic [1:0]               DATA_CACHE_STORE,
    input  logic [31:0]              WRITE_DATA,
    output logic [31:0]              DATA_OUT,
    output logic                     DATA_CACHE_READY,
    output logic [ADDRESS_WIDTH-1:0] MEM_ADDRESS,
    output logic                     MEM_READ_REQ,
    input  logic                     MEM_READ_VALID,
    input  logic [31:0]              MEM_READ_DATA,
    output logic                     MEM_WRITE_REQ,
    output logic [31:0]              MEM_WRITE_DATA,
    output logic [3:0]               MEM_WRITE_STRB,
    input  logic                     MEM_WRITE_ACK
);

    localparam int unsigned WORD_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W  = 2 + WORD_W;
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned TAG_W  = ADDRESS_WIDTH - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE
    } state_t;

    // ---------------------------------------------------------------- state
    state_t                     state_q, state_d;
    logic [LINES-1:0]           valid_q, valid_d;
    logic [WORD_W-1:0]          cnt_q, cnt_d;
    logic [31:0]                data_out_q, data_out_d;
    logic [ADDRESS_WIDTH-1:0]   mem_address_q, mem_address_d;
    logic                       mem_read_req_q, mem_read_req_d;
    logic                       mem_write_req_q, mem_write_req_d;
    logic [31:0]                mem_write_data_q, mem_write_data_d;
    logic [3:0]                 mem_write_strb_q, mem_write_strb_d;

    logic [TAG_W-1:0]           tag_q  [LINES];
    logic [31:0]                data_q [LINES*LINE_WORDS];

    // array write ports
    logic                       data_we;
    logic [IDX_W+WORD_W-1:0]    data_waddr;
    logic [31:0]                data_wdata;
    logic                       tag_we;

    // ---------------------------------------------------------------- decode
    logic [WORD_W-1:0]          req_word;
    logic [IDX_W-1:0]           req_idx;
    logic [TAG_W-1:0]           req_tag;
    logic [IDX_W-1:0]           ref_idx;
    logic [TAG_W-1:0]           ref_tag;

    assign req_word = ADDRESS[OFF_W-1:2];
    assign req_idx  = ADDRESS[OFF_W+IDX_W-1:OFF_W];
    assign req_tag  = ADDRESS[ADDRESS_WIDTH-1:OFF_W+IDX_W];
    // The refill target is recovered from the latched line-base address.
    assign ref_idx  = mem_address_q[OFF_W+IDX_W-1:OFF_W];
    assign ref_tag  = mem_address_q[ADDRESS_WIDTH-1:OFF_W+IDX_W];

    logic        is_load;
    logic        is_store;
    logic        hit;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] st_data;
    logic [3:0]  st_strb;
    logic [31:0] merged;

    assign is_store = (DATA_CACHE_STORE != 2'b00);
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign rd_word  = data_q[{req_idx, req_word}];
    assign rd_half  = ADDRESS[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (DATA_CACHE_LOAD)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: is_load = 1'b1;
            default:                                is_load = 1'b0;
        endcase
    end

    always_comb begin
        case (ADDRESS[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    always_comb begin
        case (DATA_CACHE_LOAD)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_val = {24'd0, rd_byte};
            3'b101:  load_val = {16'd0, rd_half};
            default: load_val = rd_word;
        endcase
    end

    always_comb begin
        case (DATA_CACHE_STORE)
            2'b01: begin
                st_data = {4{WRITE_DATA[7:0]}};
                st_strb = 4'b0001 << ADDRESS[1:0];
            end
            2'b10: begin
                st_data = {2{WRITE_DATA[15:0]}};
                st_strb = ADDRESS[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = WRITE_DATA;
                st_strb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        merged = rd_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (st_strb[b]) merged[8*b +: 8] = st_data[8*b +: 8];
        end
    end

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d          = state_q;
        valid_d          = valid_q;
        cnt_d            = cnt_q;
        data_out_d       = data_out_q;
        mem_address_d    = mem_address_q;
        mem_read_req_d   = mem_read_req_q;
        mem_write_req_d  = mem_write_req_q;
        mem_write_data_d = mem_write_data_q;
        mem_write_strb_d = mem_write_strb_q;
        data_we          = 1'b0;
        data_waddr       = {req_idx, req_word};
        data_wdata       = merged;
        tag_we           = 1'b0;
        DATA_CACHE_READY = 1'b1;

        case (state_q)
            IDLE: begin
                if (!STALL_DATA_CACHE) begin
                    if (is_store) begin
                        DATA_CACHE_READY = 1'b0;
                        state_d          = WRITE;
                        mem_address_d    = {ADDRESS[ADDRESS_WIDTH-1:2], 2'b00};
                        mem_write_req_d  = 1'b1;
                        mem_write_data_d = st_data;
                        mem_write_strb_d = st_strb;
                        data_we          = hit;
                    end else if (is_load) begin
                        if (hit) begin
                            data_out_d = load_val;
                        end else begin
                            DATA_CACHE_READY = 1'b0;
                            state_d          = REFILL;
                            mem_address_d    = {ADDRESS[ADDRESS_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                            mem_read_req_d   = 1'b1;
                            cnt_d            = '0;
                            // Invalidate now so a partly overwritten line
                            // (alias replacement or aborted refill) never hits.
                            valid_d[req_idx] = 1'b0;
                        end
                    end
                end
            end
            REFILL: begin
                DATA_CACHE_READY = 1'b0;
                if (MEM_READ_VALID) begin
                    data_we    = 1'b1;
                    data_waddr = {ref_idx, cnt_q};
                    data_wdata = MEM_READ_DATA;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == WORD_W'(LINE_WORDS - 1)) begin
                        tag_we           = 1'b1;
                        valid_d[ref_idx] = 1'b1;
                        cnt_d            = '0;
                        mem_read_req_d   = 1'b0;
                        state_d          = IDLE;
                    end
                end
            end
            WRITE: begin
                DATA_CACHE_READY = MEM_WRITE_ACK;
                if (MEM_WRITE_ACK) begin
                    mem_write_req_d = 1'b0;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (RST) DATA_CACHE_READY = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q          <= IDLE;
            valid_q          <= '0;
            cnt_q            <= '0;
            data_out_q       <= '0;
            mem_address_q    <= '0;
            mem_read_req_q   <= 1'b0;
            mem_write_req_q  <= 1'b0;
            mem_write_data_q <= '0;
            mem_write_strb_q <= '0;
        end else begin
            state_q          <= state_d;
            valid_q          <= valid_d;
            cnt_q            <= cnt_d;
            data_out_q       <= data_out_d;
            mem_address_q    <= mem_address_d;
            mem_read_req_q   <= mem_read_req_d;
            mem_write_req_q  <= mem_write_req_d;
            mem_write_data_q <= mem_write_data_d;
            mem_write_strb_q <= mem_write_strb_d;
        end
    end

    // Storage arrays carry no reset; contents are qualified by valid_q.
    always_ff @(posedge CLK) begin
        if (!RST && data_we) data_q[data_waddr] <= data_wdata;
        if (!RST && tag_we)  tag_q[ref_idx]     <= ref_tag;
    end

    assign DATA_OUT       = data_out_q;
    assign MEM_ADDRESS    = mem_address_q;
    assign MEM_READ_REQ   = mem_read_req_q;
    assign MEM_WRITE_REQ  = mem_write_req_q;
    assign MEM_WRITE_DATA = mem_write_data_q;
    assign MEM_WRITE_STRB = mem_write_strb_q;

endmodule

// File: tb/tb_data_cache_controller.sv
// tb_data_cache_controller
//   Directed-vector bench for data_cache_controller with default parameters
//   (64 lines x 4 words). Inputs are driven 1 time unit after the rising
//   edge; outputs are checked before the next edge.
module tb_data_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] address;
    logic [2:0]  load_code;
    logic [1:0]  store_code;
    logic [31:0] write_data;
    logic [31:0] data_out;
    logic        ready;
    logic [31:0] mem_address;
    logic        mem_read_req;
    logic        mem_read_valid;
    logic [31:0] mem_read_data;
    logic        mem_write_req;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_strb;
    logic        mem_write_ack;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    data_cache_controller #(
        .ADDRESS_WIDTH(32),
        .LINES(64),
        .LINE_WORDS(4)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .STALL_DATA_CACHE(stall),
        .ADDRESS(address),
        .DATA_CACHE_LOAD(load_code),
        .DATA_CACHE_STORE(store_code),
        .WRITE_DATA(write_data),
        .DATA_OUT(data_out),
        .DATA_CACHE_READY(ready),
        .MEM_ADDRESS(mem_address),
        .MEM_READ_REQ(mem_read_req),
        .MEM_READ_VALID(mem_read_valid),
        .MEM_READ_DATA(mem_read_data),
        .MEM_WRITE_REQ(mem_write_req),
        .MEM_WRITE_DATA(mem_write_data),
        .MEM_WRITE_STRB(mem_write_strb),
        .MEM_WRITE_ACK(mem_write_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load that misses: refill with beats beat0..beat0+3, then expect result.
    task automatic load_miss(input logic [31:0] addr, input logic [31:0] base,
                             input logic [31:0] beat0, input logic [31:0] exp);
        address   = addr;
        load_code = 3'b010;
        #1;
        check("miss_ready_low", {31'd0, ready}, 32'd0);
        tick();
        check("refill_req", {31'd0, mem_read_req}, 32'd1);
        check("refill_addr", mem_address, base);
        for (int i = 0; i < 4; i++) begin
            mem_read_valid = 1'b1;
            mem_read_data  = beat0 + 32'(i);
            #1;
            check("refill_ready_low", {31'd0, ready}, 32'd0);
            tick();
        end
        mem_read_valid = 1'b0;
        #1;
        check("refill_req_drop", {31'd0, mem_read_req}, 32'd0);
        check("post_refill_ready", {31'd0, ready}, 32'd1);
        tick();
        check("post_refill_data", data_out, exp);
        load_code = 3'b111;
    endtask

    task automatic load_hit(input string tag, input logic [31:0] addr,
                            input logic [2:0] code, input logic [31:0] exp);
        address   = addr;
        load_code = code;
        #1;
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        tick();
        check(tag, data_out, exp);
        load_code = 3'b111;
    endtask

    task automatic store_txn(input logic [31:0] addr, input logic [1:0] code,
                             input logic [31:0] wd, input int waits,
                             input logic [3:0] exp_strb, input logic [31:0] exp_data,
                             input logic [31:0] exp_addr);
        address    = addr;
        store_code = code;
        write_data = wd;
        #1;
        check("store_ready_low", {31'd0, ready}, 32'd0);
        tick();
        check("wreq", {31'd0, mem_write_req}, 32'd1);
        check("wstrb", {28'd0, mem_write_strb}, {28'd0, exp_strb});
        check("wdata", mem_write_data, exp_data);
        check("waddr", mem_address, exp_addr);
        for (int i = 0; i < waits; i++) begin
            check("write_wait_ready", {31'd0, ready}, 32'd0);
            tick();
        end
        mem_write_ack = 1'b1;
        #1;
        check("ack_ready", {31'd0, ready}, 32'd1);
        tick();
        mem_write_ack = 1'b0;
        store_code    = 2'b00;
        check("wreq_drop", {31'd0, mem_write_req}, 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        address        = '0;
        load_code      = 3'b111;
        store_code     = 2'b00;
        write_data     = '0;
        mem_read_valid = 1'b0;
        mem_read_data  = '0;
        mem_write_ack  = 1'b0;
        tick();
        tick();
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_data_out", data_out, 32'd0);
        check("rst_rreq", {31'd0, mem_read_req}, 32'd0);
        check("rst_wreq", {31'd0, mem_write_req}, 32'd0);
        check("rst_maddr", mem_address, 32'd0);
        rst = 1'b0;
        tick();

        // Line 0x100..0x10F = A0 A1 A2 A3
        load_miss(32'h100, 32'h100, 32'hA0, 32'hA0);
        load_hit("lb_107", 32'h107, 3'b000, 32'h0);
        load_hit("lw_10c", 32'h10C, 3'b010, 32'hA3);

        // Unrecognised load code is no request
        address   = 32'h108;
        load_code = 3'b011;
        #1;
        check("badcode_ready", {31'd0, ready}, 32'd1);
        tick();
        check("badcode_hold", data_out, 32'hA3);
        load_code = 3'b111;

        store_txn(32'h104, 2'b11, 32'h000000F0, 0, 4'b1111, 32'h000000F0, 32'h104);
        load_hit("lb_104", 32'h104, 3'b000, 32'hFFFFFFF0);
        load_hit("lbu_104", 32'h104, 3'b100, 32'h000000F0);
        store_txn(32'h106, 2'b10, 32'h00008001, 0, 4'b1100, 32'h80018001, 32'h104);
        load_hit("lh_106", 32'h106, 3'b001, 32'hFFFF8001);
        load_hit("lhu_106", 32'h107, 3'b101, 32'h00008001);
        load_hit("lh_104", 32'h104, 3'b001, 32'h000000F0);

        store_txn(32'h102, 2'b10, 32'h00001234, 3, 4'b1100, 32'h12341234, 32'h100);
        load_hit("lw_100_merged", 32'h100, 3'b010, 32'h123400A0);
        store_txn(32'h10B, 2'b01, 32'h0000005A, 1, 4'b1000, 32'h5A5A5A5A, 32'h108);
        load_hit("lw_108_sb", 32'h10A, 3'b010, 32'h5A0000A2);

        // Store miss: no allocate
        store_txn(32'h800, 2'b11, 32'hDEADBEEF, 2, 4'b1111, 32'hDEADBEEF, 32'h800);
        load_miss(32'h800, 32'h800, 32'hB0, 32'hB0);

        // Alias replaces line index 0x10; original line now misses
        load_miss(32'h508, 32'h500, 32'hC0, 32'hC2);
        load_hit("lw_504_alias", 32'h504, 3'b010, 32'hC1);

        // Reset aborts refill after 2 beats
        address   = 32'h100;
        load_code = 3'b010;
        #1;
        check("alias_miss_ready", {31'd0, ready}, 32'd0);
        tick();
        check("abort_rreq", {31'd0, mem_read_req}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            mem_read_valid = 1'b1;
            mem_read_data  = 32'hE0 + 32'(i);
            tick();
        end
        mem_read_valid = 1'b0;
        rst            = 1'b1;
        #1;
        check("abort_rst_ready", {31'd0, ready}, 32'd1);
        tick();
        check("abort_rreq_drop", {31'd0, mem_read_req}, 32'd0);
        rst = 1'b0;
        load_miss(32'h100, 32'h100, 32'hD0, 32'hD0);

        // Stall in IDLE with a miss pending: nothing launched, DATA_OUT holds
        stall     = 1'b1;
        address   = 32'h900;
        load_code = 3'b010;
        #1;
        check("stall_ready", {31'd0, ready}, 32'd1);
        tick();
        tick();
        check("stall_no_rreq", {31'd0, mem_read_req}, 32'd0);
        check("stall_hold", data_out, 32'hD0);
        address   = 32'h104;
        tick();
        check("stall_hit_hold", data_out, 32'hD0);
        stall     = 1'b0;
        load_code = 3'b111;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
